// File: rtl/stopwatch_ctrl.sv
// Control FSM for an MM:SS stopwatch: 1 Hz tick prescaler, start/stop/lap/clear sequencing, lap freeze and 59:59 overflow.
// Optional saturation at 59:59 (instead of wrapping) is enabled by defining STOPWATCH_SAT_EN.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int TICK_W   = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [6:0] sec_count,
    input  logic [6:0] min_count,
    output logic       sec_en,
    output logic       min_en,
    output logic       cnt_clr,
    output logic [6:0] disp_sec,
    output logic [6:0] disp_min,
    output logic       running,
    output logic       lap_active,
    output logic       ovf
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_LAP   = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [TICK_W-1:0] presc;
    logic [6:0]        lap_sec;
    logic [6:0]        lap_min;
    logic              lap_load;
    logic              clr_req;
    logic              tick;
    logic              wrap_tick;

    assign running    = (state == ST_RUN) || (state == ST_LAP);
    assign lap_active = (state == ST_LAP);
    assign disp_sec   = lap_active ? lap_sec : sec_count;
    assign disp_min   = lap_active ? lap_min : min_count;

    assign tick      = running && (presc == TICK_LAST);
    assign wrap_tick = tick && (sec_count == 7'h59) && (min_count == 7'h59);

`ifdef STOPWATCH_SAT_EN
    assign sec_en = tick && !wrap_tick;
`else
    assign sec_en = tick;
`endif
    assign min_en = sec_en && (sec_count == 7'h59);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        lap_load  = 1'b0;
        clr_req   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (btn_ss) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (btn_ss) begin
                    state_nxt = ST_PAUSE;
                end else if (btn_lr) begin
                    state_nxt = ST_LAP;
                    lap_load  = 1'b1;
                end
            end
            ST_LAP: begin
                if (btn_ss)      state_nxt = ST_PAUSE;
                else if (btn_lr) state_nxt = ST_RUN;
            end
            ST_PAUSE: begin
                if (btn_ss) begin
                    state_nxt = ST_RUN;
                end else if (btn_lr) begin
                    state_nxt = ST_IDLE;
                    clr_req   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
`ifdef STOPWATCH_SAT_EN
        // Saturating overflow overrides any button in the same cycle.
        if (wrap_tick) begin
            state_nxt = ST_PAUSE;
            lap_load  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
        if (rst) begin
            state   <= ST_IDLE;
            presc   <= '0;
            cnt_clr <= 1'b0;
            ovf     <= 1'b0;
            lap_sec <= '0;
            lap_min <= '0;
        end else begin
            state   <= state_nxt;
            cnt_clr <= clr_req;

            // PAUSE falls through untouched, keeping the fractional second.
            if (tick)                presc <= '0;
            else if (running)        presc <= presc + TICK_W'(1);
            else if (state == ST_IDLE) presc <= '0;

            if (lap_load) begin
                lap_sec <= sec_count;
                lap_min <= min_count;
            end

            if (clr_req)        ovf <= 1'b0;
            else if (wrap_tick) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at TICK_DIV=4; count inputs are driven directly by the bench.
// Expectations follow STOPWATCH_SAT_EN when the same macro is defined for the build.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_ss;
    logic       btn_lr;
    logic [6:0] sec_count;
    logic [6:0] min_count;
    logic       sec_en;
    logic       min_en;
    logic       cnt_clr;
    logic [6:0] disp_sec;
    logic [6:0] disp_min;
    logic       running;
    logic       lap_active;
    logic       ovf;

    int n_vec  = 0;
    int n_miss = 0;

    stopwatch_ctrl #(.TICK_DIV(4), .TICK_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_ss     (btn_ss),
        .btn_lr     (btn_lr),
        .sec_count  (sec_count),
        .min_count  (min_count),
        .sec_en     (sec_en),
        .min_en     (min_en),
        .cnt_clr    (cnt_clr),
        .disp_sec   (disp_sec),
        .disp_min   (disp_min),
        .running    (running),
        .lap_active (lap_active),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // All stimulus changes and checks happen on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic press(input logic ss, input logic lr);
        btn_ss = ss;
        btn_lr = lr;
        cyc();
        btn_ss = 1'b0;
        btn_lr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn_ss = 1'b0; btn_lr = 1'b0;
        sec_count = 7'h05; min_count = 7'h00;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        check("rst_running", {7'b0, running}, 8'h00);
        check("rst_sec_en",  {7'b0, sec_en},  8'h00);
        check("rst_cnt_clr", {7'b0, cnt_clr}, 8'h00);
        check("rst_ovf",     {7'b0, ovf},     8'h00);
        check("rst_lap",     {7'b0, lap_active}, 8'h00);
        check("rst_disp",    {1'b0, disp_sec}, 8'h05);

        // btn_lr in IDLE is ignored
        press(1'b0, 1'b1); #1;
        check("idle_lr_run", {7'b0, running}, 8'h00);

        // Enter RUN: prescaler 0, tick on the 4th RUN cycle, then every 4
        press(1'b1, 1'b0); #1;
        check("run_entry", {7'b0, running}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tick_%0d", i), {7'b0, sec_en}, (i % 4 == 3) ? 8'h01 : 8'h00);
            check($sformatf("min_%0d", i),  {7'b0, min_en}, 8'h00);
            cyc(); #1;
        end

        // Pause mid-period (prescaler 1 -> 2), resume keeps fraction
        cyc(); #1;
        press(1'b1, 1'b0); #1;
        check("pause_run", {7'b0, running}, 8'h00);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("pause_tick_%0d", i), {7'b0, sec_en}, 8'h00);
            cyc(); #1;
        end
        press(1'b1, 1'b0); #1;
        check("resume_c1", {7'b0, sec_en}, 8'h00);
        cyc(); #1;
        check("resume_c2", {7'b0, sec_en}, 8'h01);
        cyc(); #1;

        // Lap freeze at 37 while live count advances
        sec_count = 7'h37;
        press(1'b0, 1'b1); #1;
        check("lap_active", {7'b0, lap_active}, 8'h01);
        check("lap_running", {7'b0, running}, 8'h01);
        sec_count = 7'h38; #1;
        check("lap_freeze1", {1'b0, disp_sec}, 8'h37);
        cyc(); sec_count = 7'h39; #1;
        check("lap_freeze2", {1'b0, disp_sec}, 8'h37);
        cyc(); #1;
        check("lap_tick", {7'b0, sec_en}, 8'h01);
        cyc(); #1;
        sec_count = 7'h41;
        press(1'b0, 1'b1); #1;
        check("lap_release", {7'b0, lap_active}, 8'h00);
        check("lap_live", {1'b0, disp_sec}, 8'h41);

        // Minute carry at xx:59 (prescaler now 1)
        sec_count = 7'h59; min_count = 7'h12;
        cyc(); cyc(); #1;
        check("carry_sec_en", {7'b0, sec_en}, 8'h01);
        check("carry_min_en", {7'b0, min_en}, 8'h01);
        cyc(); #1;
        check("carry_ovf", {7'b0, ovf}, 8'h00);

        // Overflow at 59:59 (prescaler now 0)
        min_count = 7'h59;
        cyc(); cyc(); cyc(); #1;
`ifdef STOPWATCH_SAT_EN
        check("ovf_sec_en", {7'b0, sec_en}, 8'h00);
        check("ovf_min_en", {7'b0, min_en}, 8'h00);
`else
        check("ovf_sec_en", {7'b0, sec_en}, 8'h01);
        check("ovf_min_en", {7'b0, min_en}, 8'h01);
`endif
        cyc(); #1;
        check("ovf_set", {7'b0, ovf}, 8'h01);
        sec_count = 7'h00; min_count = 7'h00;
`ifdef STOPWATCH_SAT_EN
        check("ovf_sat_pause", {7'b0, running}, 8'h00);
`else
        check("ovf_wrap_run", {7'b0, running}, 8'h01);
        press(1'b1, 1'b0); #1;
`endif

        // PAUSE: both buttons -> RUN, no clear
        press(1'b1, 1'b1); #1;
        check("both_run", {7'b0, running}, 8'h01);
        check("both_noclr", {7'b0, cnt_clr}, 8'h00);
        check("both_ovf", {7'b0, ovf}, 8'h01);
        press(1'b1, 1'b0); #1;
        check("repause", {7'b0, running}, 8'h00);

        // PAUSE: btn_lr -> IDLE with one-cycle clear, ovf cleared
        press(1'b0, 1'b1); #1;
        check("clr_pulse", {7'b0, cnt_clr}, 8'h01);
        check("clr_ovf", {7'b0, ovf}, 8'h00);
        check("clr_idle", {7'b0, running}, 8'h00);
        cyc(); #1;
        check("clr_once", {7'b0, cnt_clr}, 8'h00);

        // Reset mid-run returns to IDLE
        press(1'b1, 1'b0); #1;
        check("rerun", {7'b0, running}, 8'h01);
        rst = 1'b1;
        cyc(); #1;
        rst = 1'b0;
        check("midrst_idle", {7'b0, running}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM for a MM:SS stopwatch built from two cascaded mod-60 BCD counter blocks (seconds, minutes).
- Generates the 1 Hz count enable from the system clock.
- Sequences start/stop/lap/clear from debounced single-cycle button pulses.
- Freezes the displayed time during lap hold.
- Reads the live BCD counts back to produce the minute enable and overflow handling.

Parameters:
TICK_DIV, 50000000, clk cycles per count tick (>=2)
TICK_W, 26, prescaler width; must satisfy 2^TICK_W >= TICK_DIV

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
btn_ss  in  1  start/stop pulse, 1 cycle
btn_lr  in  1  lap/reset pulse, 1 cycle
sec_count  in  7  live seconds BCD {tens[2:0],units[3:0]}
min_count  in  7  live minutes BCD, same format
sec_en  out  1  enable to seconds counter
min_en  out  1  enable to minutes counter
cnt_clr  out  1  clear pulse to both counters (integrator ORs with rst)
disp_sec  out  7  displayed seconds BCD
disp_min  out  7  displayed minutes BCD
running  out  1  1 in RUN or LAP
lap_active  out  1  1 in LAP
ovf  out  1  sticky 59:59 rollover flag

Behaviour:
- Reset values: state=IDLE, prescaler=0, cnt_clr=0, ovf=0, lap latches=0. disp_* follow the live inputs; all other outputs are 0.
- States and transitions. btn_ss has priority when both buttons pulse in the same cycle; the other pulse is dropped.
  - IDLE: btn_ss -> RUN. btn_lr is ignored.
  - RUN: btn_ss -> PAUSE. btn_lr -> LAP, latching sec_count/min_count as sampled in the press cycle.
  - LAP: btn_ss -> PAUSE; freeze released, display goes live. btn_lr -> RUN; freeze released.
  - PAUSE: btn_ss -> RUN. btn_lr -> IDLE, with cnt_clr registered high for exactly 1 cycle (the cycle after the press). ovf is cleared on the same edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN/LAP and wraps to 0.
  - Holds its value in PAUSE, so a resume keeps the fractional second.
  - Forced to 0 in IDLE.
- sec_en (combinational): (state in RUN or LAP) and prescaler==TICK_DIV-1. High exactly 1 cycle per TICK_DIV cycles. The counters update on the following edge.
- If btn_ss arrives in the same cycle as a tick: the tick is still issued (state changes on the edge).
- min_en (combinational): sec_en and sec_count==7'h59.
- Rollover: sec_en and sec_count==7'h59 and min_count==7'h59 is an overflow tick. Without the optional feature, counters wrap to 00:00 and ovf sets on that edge and stays set until the PAUSE->IDLE clear or rst.
- disp_*: the latched values while lap_active, otherwise sec_count/min_count passed through combinationally.
- rst mid-operation: state returns to IDLE on the next edge regardless of the buttons; the prescaler fraction is lost.
- Input count values are trusted (valid BCD 00..59); there is no range checking.

Optional Feature:
- Macro: STOPWATCH_SAT_EN.
- Defined: on an overflow tick, sec_en and min_en are suppressed, so the counters hold 59:59. The FSM moves to PAUSE, the lap freeze is released, and ovf sets. btn_ss from PAUSE in this condition re-enters RUN, and the next tick saturates again immediately.
- Undefined: wrap behaviour as above.

Test Plan:
- TICK_DIV=4, rst, btn_ss -> RUN. sec_en pulses every 4 cycles starting 4 cycles after entry. min_en=0 while sec_count!=59.
- RUN 2 cycles into a tick period, btn_ss -> PAUSE (no sec_en). After 10 idle cycles, btn_ss -> first sec_en exactly 2 cycles after re-entering RUN.
- sec_count=7'h37 with btn_lr in RUN -> lap_active=1, disp_sec stays 7'h37 while sec_count advances. A second btn_lr -> disp_sec tracks the live value the same cycle.
- sec_count=7'h59, min_count=7'h12 at a tick -> min_en=1 in the same cycle as sec_en. ovf stays 0.
- 59:59 at a tick -> default: both enables are 1 and ovf=1 next cycle. With STOPWATCH_SAT_EN: enables are 0, state is PAUSE, running=0, ovf=1.
- PAUSE with btn_ss and btn_lr in the same cycle -> RUN and no cnt_clr. Separately, btn_lr in PAUSE -> cnt_clr=1 for one cycle, state IDLE, ovf=0.
